// File: rtl/puf_vote_sequencer.sv
// puf_vote_sequencer: majority-vote trial sequencer for a ring-oscillator PUF.
// Define PUF_TIMEOUT_EN to enable the per-trial watchdog and sticky ERROR.
module puf_vote_sequencer #(
  parameter int CHAL_W         = 8,
  parameter int RESP_W         = 8,
  parameter int NUM_VOTES      = 5,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              SWEEP,
  input  logic [CHAL_W-1:0] CHALLENGE_IN,
  output logic [CHAL_W-1:0] PUF_CHALLENGE,
  output logic              PUF_START,
  input  logic              PUF_DONE,
  input  logic [RESP_W-1:0] PUF_RESPONSE,
  output logic [RESP_W-1:0] RESPONSE,
  output logic [CHAL_W-1:0] RESP_CHAL,
  output logic              RESP_VALID,
  output logic              STABLE,
  output logic              BUSY,
  output logic              SWEEP_DONE,
  output logic              ERROR
);

  localparam int CW = $clog2(NUM_VOTES + 1);
  localparam logic [CW-1:0] VOTES = CW'(NUM_VOTES);
  localparam logic [CW-1:0] HALF  = CW'(NUM_VOTES / 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_EMIT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CHAL_W-1:0] r_chal;
  logic              r_mode;
  logic              r_armed;
  logic [CW-1:0]     r_trial;
  logic [CW-1:0]     r_ones [RESP_W];
  logic [RESP_W-1:0] r_response;
  logic [CHAL_W-1:0] r_resp_chal;
  logic              r_stable;
  logic              r_sweep_done;

  logic [CW-1:0]     w_ones_nxt [RESP_W];
  logic [RESP_W-1:0] w_vote;
  logic [RESP_W-1:0] w_bit_stable;
  logic [CW-1:0]     w_trial_nxt;
  logic              w_accept;
  logic              w_last;
  logic              w_all_ones;
  logic              w_timeout;

  for (genvar g = 0; g < RESP_W; g++) begin : g_bit
    assign w_ones_nxt[g]   = r_ones[g] + CW'(PUF_RESPONSE[g]);
    assign w_vote[g]       = w_ones_nxt[g] > HALF;
    assign w_bit_stable[g] = (w_ones_nxt[g] == '0) ||
                             (w_ones_nxt[g] == VOTES);
  end

  // A done level left over from the previous trial must drop before
  // it can be accepted again.
  assign w_accept    = (r_state == S_WAIT) && PUF_DONE && r_armed;
  assign w_trial_nxt = r_trial + CW'(1);
  assign w_last      = w_accept && (w_trial_nxt == VOTES);
  assign w_all_ones  = &r_chal;

`ifdef PUF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_wd;
  logic          r_error;

  assign w_timeout = (r_state == S_WAIT) && !w_accept &&
                     (r_wd == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wd    <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state == S_LAUNCH) begin
        r_wd <= '0;
      end else if (r_state == S_WAIT) begin
        r_wd <= r_wd + TW'(1);
      end
      if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end

  assign ERROR = r_error;
`else
  logic w_unused_tmo;

  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
  assign ERROR        = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_accept) begin
          w_state_nxt = w_last ? S_EMIT : S_LAUNCH;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EMIT: begin
        if (!r_mode || w_all_ones) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_LAUNCH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_chal       <= '0;
      r_mode       <= 1'b0;
      r_armed      <= 1'b0;
      r_trial      <= '0;
      r_response   <= '0;
      r_resp_chal  <= '0;
      r_stable     <= 1'b0;
      r_sweep_done <= 1'b0;
      for (int i = 0; i < RESP_W; i++) begin
        r_ones[i] <= '0;
      end
    end else begin
      r_sweep_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_chal  <= CHALLENGE_IN;
            r_mode  <= SWEEP;
            r_trial <= '0;
            for (int i = 0; i < RESP_W; i++) begin
              r_ones[i] <= '0;
            end
          end
        end
        S_LAUNCH: begin
          r_armed <= 1'b0;
        end
        S_WAIT: begin
          if (!PUF_DONE) begin
            r_armed <= 1'b1;
          end
          if (w_accept) begin
            r_trial <= w_trial_nxt;
            for (int i = 0; i < RESP_W; i++) begin
              r_ones[i] <= w_ones_nxt[i];
            end
          end
          // Results are registered on the final accept so they are
          // already valid while RESP_VALID is high in EMIT.
          if (w_last) begin
            r_response  <= w_vote;
            r_stable    <= &w_bit_stable;
            r_resp_chal <= r_chal;
          end
        end
        S_EMIT: begin
          if (r_mode && w_all_ones) begin
            r_sweep_done <= 1'b1;
          end else if (r_mode) begin
            r_chal  <= r_chal + CHAL_W'(1);
            r_trial <= '0;
            for (int i = 0; i < RESP_W; i++) begin
              r_ones[i] <= '0;
            end
          end
        end
        default: begin
          r_armed <= 1'b0;
        end
      endcase
    end
  end

  assign PUF_CHALLENGE = r_chal;
  assign PUF_START     = (r_state == S_LAUNCH);
  assign RESP_VALID    = (r_state == S_EMIT);
  assign BUSY          = (r_state != S_IDLE);
  assign RESPONSE      = r_response;
  assign RESP_CHAL     = r_resp_chal;
  assign STABLE        = r_stable;
  assign SWEEP_DONE    = r_sweep_done;

endmodule
